bootram_bus_bridge: RTL and testbench
=====================================

# bootram_bus_bridge

Bridge between the PicoRV32 native memory bus (32-bit word, byte strobes) and the 2K×8 single-port boot RAM macro (registered address, one-cycle read latency).
- Sits directly upstream of the boot RAM and is its only master.
- Serialises each 32-bit CPU access into four byte accesses and reassembles read data little-endian.
- Returns `mem_ready` with fixed latency per access type.

## Interface
Parameters
- `ADDR_W`, default 11: boot RAM byte-address width (2^ADDR_W bytes).
- `WRITE_EN`, default 1: 0 makes the RAM read-only; writes complete normally but never assert `ram_wre`.

Ports
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `mem_valid` in 1: access request, already qualified by the address decoder for this region.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_addr` in 32: byte address; only bits [ADDR_W-1:2] are used.
- `mem_wdata` in 32: write data; lane k = bits [8k+7:8k].
- `mem_wstrb` in 4: byte enables; all zero means read.
- `mem_rdata` out 32: read data; valid while `mem_ready`=1 after a read.
- `ram_ce` out 1: RAM clock enable.
- `ram_oce` out 1: RAM output clock enable; constant 1.
- `ram_wre` out 1: RAM write enable.
- `ram_reset` out 1: equals `reset`.
- `ram_ad` out ADDR_W: RAM byte address.
- `ram_din` out 8: RAM write byte.
- `ram_dout` in 8: RAM read byte; valid one cycle after the address is presented with `ram_ce`=1.

## Operation
States: IDLE, RD, RDLAST, WR, DONE. A 2-bit lane counter `cnt` runs in RD and WR.

- **IDLE**
  - On `mem_valid`=1, latch word address `mem_addr[ADDR_W-1:2]`, `mem_wdata` and `mem_wstrb`, and clear `cnt`.
  - If `mem_wstrb`==0, go to RD; otherwise go to WR.
- **RD**
  - `ram_ce`=1, `ram_wre`=0, `ram_ad`={word, `cnt`}.
  - Each cycle after the first, capture `ram_dout` into `mem_rdata` lane `cnt`-1.
  - When `cnt`==3, go to RDLAST.
- **RDLAST**
  - `ram_ce`=0.
  - Capture `ram_dout` into `mem_rdata[31:24]`, then go to DONE.
- **WR**
  - `ram_ad`={word, `cnt`}, `ram_din`=latched lane `cnt`.
  - `ram_ce`=`ram_wre`=`wstrb[cnt]` & `WRITE_EN`.
  - Lanes with a zero strobe are still stepped through, so write latency is fixed.
  - When `cnt`==3, go to DONE.
- **DONE**
  - `mem_ready`=1 for exactly one cycle, then go to IDLE.
  - `mem_valid` is not sampled in DONE. PicoRV32 drops `mem_valid` the cycle after `mem_ready`, so no request is double-accepted.

Data and arithmetic rules
- `mem_rdata` is a register. It is updated only by read captures and holds its value across writes and idle.
- The lane counter wraps 3→0 only on exit from RD or WR. Word addresses wrap modulo 2^(ADDR_W-2).
- Changes on `mem_*` inputs after acceptance are ignored until the next IDLE.

## Timing
Cycle 0 is the IDLE cycle in which `mem_valid` is sampled high.
- **Read**
  - RD in cycles 1–4; captures in cycles 2–5.
  - RDLAST in cycle 5; DONE in cycle 6.
  - `mem_ready`=1 in cycle 6: 6-cycle latency.
- **Write**
  - WR in cycles 1–4; DONE in cycle 5.
  - `mem_ready`=1 in cycle 5: 5-cycle latency.
- **Throughput:** the next request is accepted no earlier than the cycle after DONE.

Reset values (all outputs are decoded from registers)
- state = IDLE, `cnt` = 0.
- `mem_ready`, `ram_ce`, `ram_wre` = 0.
- `mem_rdata`, `ram_ad`, `ram_din` = 0.
- `ram_oce` = 1.

Reset mid-access: the cycle after `reset` is sampled high, all of the above values apply and no further RAM access is issued. A partially written word stays partially written, with no rollback.

Simultaneous `reset` and `mem_valid`: reset wins and the request is not accepted.

## Structure
- Package `bootram_bridge_pkg`:
  - state enum `bridge_state_t`;
  - `LANES`=4;
  - `RD_LATENCY`=6, `WR_LATENCY`=5, shared with the bench.
- Single module, no sub-module: FSM, lane counter, byte mux and read-assembly register.

## Test plan
- **Read after init.** RAM preloaded with bytes 0x6F,0x13,0x13,0x13 at 0x000–0x003; read `mem_addr`=0x0 → `mem_ready` in cycle 6 with `mem_rdata`=0x1313136F; RAM sees `ram_ad` 0,1,2,3 in cycles 1–4.
- **Full write then read.** Write 0xDEADBEEF, wstrb=4'hF, to 0x104 → `ram_wre` in cycles 1–4 with `ram_ad` 0x104–0x107 and `ram_din` EF,BE,AD,DE; `mem_ready` in cycle 5; a subsequent read returns 0xDEADBEEF.
- **Partial strobes.** Write 0x11223344 with wstrb=4'b0101 over 0xDEADBEEF → only lanes 0 and 2 write; `mem_ready` still in cycle 5; read-back returns 0xDE22BE44.
- **Read-only build.** With `WRITE_EN`=0, any write → `ram_wre` never asserts and `mem_ready` arrives in cycle 5; read-back is unchanged.
- **Reset mid-read.** Assert `reset` in cycle 3 of a read → next cycle state is IDLE, `ram_ce`=0, `mem_rdata`=0, and `mem_ready` never pulses; a fresh read after reset completes in 6 cycles.
- **Back-to-back and wrap.** Hold `mem_valid` high across DONE → the second access is accepted only in the IDLE cycle after DONE. A read at 0x7FC returns bytes 0x7FC–0x7FF; `mem_addr`=0x800 aliases to RAM byte 0x000.

Source files
------------

// File: rtl/bootram_bus_bridge_pkg.sv
// Shared definitions for the PicoRV32-to-boot-RAM byte-serialising bridge.
package bootram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDLAST,
    ST_WR,
    ST_DONE
  } bridge_state_t;

  localparam int unsigned LANES      = 4;
  localparam int unsigned RD_LATENCY = 6;
  localparam int unsigned WR_LATENCY = 5;

endpackage

// File: rtl/bootram_bus_bridge.sv
// Serialises 32-bit PicoRV32 accesses into four byte accesses on a
// 2^ADDR_W x 8 single-port boot RAM with one-cycle read latency.
module bootram_bus_bridge
  import bootram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned WRITE_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);

  localparam int unsigned WORD_W    = ADDR_W - 2;
  localparam logic [1:0]  LAST_LANE = 2'(LANES - 1);
  localparam bit          WR_ALLOW  = (WRITE_EN != 0);

  bridge_state_t     state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              lane_we;

  // Address bits outside the RAM word range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};

  // State, lane counter, latched request and read-assembly register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic, read captures and RAM strobes decoded from state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    mem_ready = 1'b0;
    ram_ce    = 1'b0;
    ram_wre   = 1'b0;
    lane_we   = wstrb_q[cnt_q] & WR_ALLOW;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          word_d  = mem_addr[ADDR_W-1:2];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cnt_d   = '0;
          state_d = (mem_wstrb == 4'h0) ? ST_RD : ST_WR;
        end
      end
      ST_RD: begin
        ram_ce = 1'b1;
        // Data for lane cnt-1 appears one cycle after its address.
        if (cnt_q != 2'd0) begin
          rdata_d[{cnt_q - 2'd1, 3'b000} +: 8] = ram_dout;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_LANE) begin
          state_d = ST_RDLAST;
        end
      end
      ST_RDLAST: begin
        rdata_d[31:24] = ram_dout;
        state_d        = ST_DONE;
      end
      ST_WR: begin
        ram_ce  = lane_we;
        ram_wre = lane_we;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == LAST_LANE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        mem_ready = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_rdata = rdata_q;
  assign ram_ad    = {word_q, cnt_q};
  assign ram_din   = wdata_q[{cnt_q, 3'b000} +: 8];
  assign ram_oce   = 1'b1;
  assign ram_reset = reset;

endmodule

// File: tb/tb_bootram_bus_bridge.sv
// Bench for bootram_bus_bridge: a writable instance and a read-only instance,
// each backed by a behavioural byte RAM, checked against a shadow memory.
module tb_bootram_bus_bridge;
  import bootram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mv_a, mv_b;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        rdy_a, ce_a, oce_a, wre_a, rrst_a;
  logic        rdy_b, ce_b, oce_b, wre_b, rrst_b;
  logic [31:0] rdata_a, rdata_b;
  logic [10:0] ad_a, ad_b;
  logic [7:0]  din_a, din_b, dout_a, dout_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  shadow [0:2047];
  logic [31:0] exp_q [$];

  logic [10:0] ad_log  [0:31];
  logic [7:0]  din_log [0:31];
  logic        wre_log [0:31];
  logic        ce_log  [0:31];

  always #5 clk = ~clk;

  bootram_bus_bridge #(.ADDR_W(11), .WRITE_EN(1)) dut_a (
    .clk(clk), .reset(reset), .mem_valid(mv_a), .mem_ready(rdy_a),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(rdata_a), .ram_ce(ce_a), .ram_oce(oce_a), .ram_wre(wre_a),
    .ram_reset(rrst_a), .ram_ad(ad_a), .ram_din(din_a), .ram_dout(dout_a)
  );

  bootram_bus_bridge #(.ADDR_W(11), .WRITE_EN(0)) dut_b (
    .clk(clk), .reset(reset), .mem_valid(mv_b), .mem_ready(rdy_b),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(rdata_b), .ram_ce(ce_b), .ram_oce(oce_b), .ram_wre(wre_b),
    .ram_reset(rrst_b), .ram_ad(ad_b), .ram_din(din_b), .ram_dout(dout_b)
  );

  function automatic logic [7:0] init_byte(int unsigned i);
    case (i)
      0:       return 8'h6F;
      1, 2, 3: return 8'h13;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  // Behavioural boot RAMs: registered address, one-cycle read latency.
  logic [7:0] ram_a [0:2047];
  logic [7:0] ram_b [0:2047];
  bit         ram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 2048; i++) begin
        ram_a[i] <= init_byte(i);
        ram_b[i] <= init_byte(i);
      end
      ram_init_done <= 1'b1;
    end else begin
      if (ce_a) begin
        if (wre_a) ram_a[ad_a] <= din_a;
        else       dout_a <= ram_a[ad_a];
      end
      if (ce_b) begin
        if (wre_b) ram_b[ad_b] <= din_b;
        else       dout_b <= ram_b[ad_b];
      end
    end
  end

  function automatic logic [31:0] model_read(bit sel, logic [31:0] addr);
    logic [31:0] w;
    for (int l = 0; l < 4; l++) begin
      if (sel) w[8*l +: 8] = init_byte({addr[10:2], 2'(l)});
      else     w[8*l +: 8] = shadow[{addr[10:2], 2'(l)}];
    end
    return w;
  endfunction

  // Drives one access starting in cycle 0 and logs RAM-side signals per cycle.
  // Returns the cycle index of mem_ready (-1 if it never came).
  task automatic issue(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit hold,
                       output int lat, output logic [31:0] rdata);
    lat = -1;
    rdata = '0;
    for (int k = 0; k < 32; k++) begin
      ad_log[k] = '0; din_log[k] = '0; wre_log[k] = 1'b0; ce_log[k] = 1'b0;
    end
    if (strb == 4'h0) exp_q.push_back(model_read(sel, addr));
    else if (!sel) begin
      for (int l = 0; l < 4; l++)
        if (strb[l]) shadow[{addr[10:2], 2'(l)}] = wdata[8*l +: 8];
    end
    mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    mv_a = !sel; mv_b = sel;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        if (hold) begin
          mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'hA;
        end else begin
          mv_a = 1'b0; mv_b = 1'b0;
        end
      end
      @(negedge clk);
      ad_log[k]  = sel ? ad_b  : ad_a;
      din_log[k] = sel ? din_b : din_a;
      wre_log[k] = sel ? wre_b : wre_a;
      ce_log[k]  = sel ? ce_b  : ce_a;
      if ((sel ? rdy_b : rdy_a) === 1'b1) begin
        lat = k;
        rdata = sel ? rdata_b : rdata_a;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mv_a = 1'b0; mv_b = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({rrst_a, rrst_b} !== 2'b11) $display("FAIL reset_passthru: got %b want 11", {rrst_a, rrst_b});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({rdy_a, ce_a, wre_a, oce_a, rrst_a, rdata_a, ad_a, din_a} !== {5'b00010, 32'h0, 11'h0, 8'h0})
      $display("FAIL reset_a: got rdy%b ce%b wre%b oce%b rst%b rdata %h ad %h din %h want 0,0,0,1,0,0,0,0",
               rdy_a, ce_a, wre_a, oce_a, rrst_a, rdata_a, ad_a, din_a);
    else pass_cnt++;
    total_cnt++;
    if ({rdy_b, ce_b, wre_b, oce_b, rdata_b, ad_b, din_b} !== {4'b0001, 32'h0, 11'h0, 8'h0})
      $display("FAIL reset_b: got rdy%b ce%b wre%b oce%b rdata %h ad %h din %h want 0,0,0,1,0,0,0",
               rdy_b, ce_b, wre_b, oce_b, rdata_b, ad_b, din_b);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_read_init();
    int lat; logic [31:0] rd, ex;
    issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, lat, rd);
    ex = exp_q.pop_front();
    total_cnt++;
    if (lat != int'(RD_LATENCY)) $display("FAIL init_read_latency: got %0d want %0d", lat, RD_LATENCY);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h1313136F || ex !== 32'h1313136F)
      $display("FAIL init_read_data: got %h want 1313136f (model %h)", rd, ex);
    else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      total_cnt++;
      if ({ce_log[k], wre_log[k], ad_log[k]} !== {2'b10, 11'(k - 1)})
        $display("FAIL init_read_cycle%0d: got ce%b wre%b ad %h want ce1 wre0 ad %h",
                 k, ce_log[k], wre_log[k], ad_log[k], k - 1);
      else pass_cnt++;
    end
    total_cnt++;
    if (ce_log[5] !== 1'b0) $display("FAIL init_read_rdlast_ce: got %b want 0", ce_log[5]);
    else pass_cnt++;
  endtask

  task automatic test_full_write();
    int lat; logic [31:0] rd, ex; logic [31:0] w;
    w = 32'hDEADBEEF;
    issue(1'b0, 32'h104, w, 4'hF, 1'b0, lat, rd);
    total_cnt++;
    if (lat != int'(WR_LATENCY)) $display("FAIL full_write_latency: got %0d want %0d", lat, WR_LATENCY);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h1313136F) $display("FAIL rdata_hold_on_write: got %h want 1313136f", rd);
    else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      total_cnt++;
      if ({wre_log[k], ce_log[k], ad_log[k], din_log[k]} !== {2'b11, 11'(32'h104 + k - 1), w[8*(k-1) +: 8]})
        $display("FAIL full_write_cycle%0d: got wre%b ce%b ad %h din %h want wre1 ce1 ad %h din %h",
                 k, wre_log[k], ce_log[k], ad_log[k], din_log[k], 32'h104 + k - 1, w[8*(k-1) +: 8]);
      else pass_cnt++;
    end
    issue(1'b0, 32'h104, 32'h0, 4'h0, 1'b0, lat, rd);
    ex = exp_q.pop_front();
    total_cnt++;
    if (lat != int'(RD_LATENCY) || rd !== ex || ex !== 32'hDEADBEEF)
      $display("FAIL full_write_readback: got %h lat %0d want deadbeef lat %0d", rd, lat, RD_LATENCY);
    else pass_cnt++;
  endtask

  task automatic test_partial_strobe();
    int lat; logic [31:0] rd, ex; logic [3:0] s;
    s = 4'b0101;
    issue(1'b0, 32'h104, 32'h11223344, s, 1'b0, lat, rd);
    total_cnt++;
    if (lat != int'(WR_LATENCY)) $display("FAIL partial_latency: got %0d want %0d", lat, WR_LATENCY);
    else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      total_cnt++;
      if ({wre_log[k], ce_log[k]} !== {s[k-1], s[k-1]})
        $display("FAIL partial_strobe_lane%0d: got wre%b ce%b want %b", k - 1, wre_log[k], ce_log[k], s[k-1]);
      else pass_cnt++;
    end
    issue(1'b0, 32'h104, 32'h0, 4'h0, 1'b0, lat, rd);
    ex = exp_q.pop_front();
    total_cnt++;
    if (rd !== ex || ex !== 32'hDE22BE44) $display("FAIL partial_readback: got %h want de22be44", rd);
    else pass_cnt++;
  endtask

  task automatic test_read_only();
    int lat; logic [31:0] rd, ex; int wre_seen;
    issue(1'b1, 32'h0, 32'h55AA55AA, 4'hF, 1'b0, lat, rd);
    wre_seen = 0;
    for (int k = 1; k <= 6; k++) if (wre_log[k] !== 1'b0 || ce_log[k] !== 1'b0) wre_seen++;
    total_cnt++;
    if (lat != int'(WR_LATENCY)) $display("FAIL ro_write_latency: got %0d want %0d", lat, WR_LATENCY);
    else pass_cnt++;
    total_cnt++;
    if (wre_seen != 0) $display("FAIL ro_write_strobe: got %0d active cycles want 0", wre_seen);
    else pass_cnt++;
    issue(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, lat, rd);
    ex = exp_q.pop_front();
    total_cnt++;
    if (lat != int'(RD_LATENCY) || rd !== ex || ex !== 32'h1313136F)
      $display("FAIL ro_readback: got %h lat %0d want 1313136f lat %0d", rd, lat, RD_LATENCY);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    int lat, rdy_seen, ce_seen; logic [31:0] rd, ex;
    mem_addr = 32'h104; mem_wdata = '0; mem_wstrb = 4'h0; mv_a = 1'b1;
    @(posedge clk); #1; mv_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({rdy_a, ce_a, wre_a, rdata_a, ad_a} !== {3'b000, 32'h0, 11'h0})
      $display("FAIL mid_read_reset: got rdy%b ce%b wre%b rdata %h ad %h want all zero",
               rdy_a, ce_a, wre_a, rdata_a, ad_a);
    else pass_cnt++;
    rdy_seen = 0; ce_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy_a === 1'b1) rdy_seen++;
      if (ce_a === 1'b1) ce_seen++;
    end
    total_cnt++;
    if (rdy_seen != 0 || ce_seen != 0)
      $display("FAIL mid_read_quiet: got %0d ready %0d ce want 0 0", rdy_seen, ce_seen);
    else pass_cnt++;
    // Reset and request in the same cycle: the request must be dropped.
    @(posedge clk); #1; reset = 1'b1; mv_a = 1'b1;
    @(posedge clk); #1; reset = 1'b0; mv_a = 1'b0;
    rdy_seen = 0; ce_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdy_a === 1'b1) rdy_seen++;
      if (ce_a === 1'b1) ce_seen++;
    end
    total_cnt++;
    if (rdy_seen != 0 || ce_seen != 0)
      $display("FAIL reset_wins: got %0d ready %0d ce want 0 0", rdy_seen, ce_seen);
    else pass_cnt++;
    @(posedge clk); #1;
    issue(1'b0, 32'h104, 32'h0, 4'h0, 1'b0, lat, rd);
    ex = exp_q.pop_front();
    total_cnt++;
    if (lat != int'(RD_LATENCY) || rd !== ex)
      $display("FAIL post_reset_read: got %h lat %0d want %h lat %0d", rd, lat, ex, RD_LATENCY);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, ex;
    issue(1'b0, 32'h200, 32'hCAFEF00D, 4'hF, 1'b1, lat, rd);
    total_cnt++;
    if (lat != int'(WR_LATENCY)) $display("FAIL b2b_first_latency: got %0d want %0d", lat, WR_LATENCY);
    else pass_cnt++;
    issue(1'b0, 32'h200, 32'h0, 4'h0, 1'b0, lat, rd);
    ex = exp_q.pop_front();
    total_cnt++;
    if (lat != int'(RD_LATENCY)) $display("FAIL b2b_second_latency: got %0d want %0d", lat, RD_LATENCY);
    else pass_cnt++;
    total_cnt++;
    if (rd !== ex || ex !== 32'hCAFEF00D) $display("FAIL b2b_data: got %h want cafef00d", rd);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd, ex;
    issue(1'b0, 32'h7FC, 32'h0, 4'h0, 1'b0, lat, rd);
    ex = exp_q.pop_front();
    total_cnt++;
    if (rd !== ex || ad_log[1] !== 11'h7FC || ad_log[4] !== 11'h7FF)
      $display("FAIL top_word_read: got %h ad %h..%h want %h ad 7fc..7ff", rd, ad_log[1], ad_log[4], ex);
    else pass_cnt++;
    issue(1'b0, 32'h800, 32'h0, 4'h0, 1'b0, lat, rd);
    ex = exp_q.pop_front();
    total_cnt++;
    if (rd !== 32'h1313136F || ad_log[1] !== 11'h000 || lat != int'(RD_LATENCY))
      $display("FAIL alias_read: got %h ad %h lat %0d want 1313136f ad 000 lat %0d (model %h)",
               rd, ad_log[1], lat, RD_LATENCY, ex);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) shadow[i] = init_byte(i);
    test_reset();
    test_read_init();
    test_full_write();
    test_partial_strobe();
    test_read_only();
    test_reset_mid_read();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
